tiny_dnn_out_fifo: RTL
======================

// Module: tiny_dnn_out_fifo
// PURPOSE
//  Downstream of normalize: takes each fp32 neuron result (nrm) when its
//  producer asserts nrm_valid, rounds it to bfloat16 (RNE), optionally applies
//  ReLU, and buffers it in a DEPTH-entry FIFO drained by a valid/ready consumer
//  (next-layer d input or host readback). Decouples core timing from the sink.
// PARAMETERS
//  DEPTH   4   FIFO entries; power of 2, >=2
//  AW      2   log2(DEPTH); count width is AW+1
// PORTS
//  clk        in   1    clock
//  init       in   1    synchronous active-high reset
//  nrm_valid  in   1    nrm holds a result this cycle
//  nrm        in   32   fp32 from normalize (zero or normal; never NaN/denormal)
//  in_ready   out  1    block can accept nrm this cycle
//  out_valid  out  1    out_data is valid
//  out_data   out  16   bfloat16 result, FIFO head
//  out_ready  in   1    sink accepts out_data this cycle
//  count      out  AW+1 entries held in FIFO (excludes stage-1)
//  drop       out  1    sticky: nrm_valid seen while in_ready=0
// BEHAVIOUR
//  Reset (init=1): all of in_ready=0, out_valid=0, out_data=0, count=0, drop=0,
//   s1_valid=0, pointers=0. in_ready returns to 1 the cycle after init drops.
//   init mid-operation discards stage-1 and all FIFO contents.
//  Push = nrm_valid & in_ready; pop = out_valid & out_ready.
//  Stage 1 (register): on push capture bf16 = rnd(nrm); s1_valid<=push.
//  Rounding: hi=nrm[31:16]; inc = nrm[15] & (nrm[16] | |nrm[14:0]);
//   bf16 = hi + inc (16-bit add; mantissa carry bumps exponent; 0x7F7F+1
//   yields 0x7F80 = +inf; sign bit never changes).
//  Stage 2: s1_valid writes stage-1 word at wr_ptr, wr_ptr++ (wraps mod DEPTH).
//  Latency: push at cycle t -> out_valid at t+2 if FIFO was empty.
//  out_data = mem[rd_ptr], registered, valid whenever count>0; held stable
//   while out_valid & ~out_ready. Pop: rd_ptr++ (wrap), count--.
//  in_ready = (count + s1_valid) < DEPTH, from registered state only
//   (no combinational out_ready->in_ready path).
//  Simultaneous stage-2 write and pop: count unchanged, both pointers advance;
//   legal at count=DEPTH only via the in_ready rule (never overfills).
//  Empty: pop impossible (out_valid=0); out_data keeps last value.
//  nrm_valid while in_ready=0: sample ignored, drop<=1 until init.
//  count never exceeds DEPTH; overflow/underflow of pointers is impossible.
// CONFIGURATION
//  RELU_EN defined: in stage 1, if nrm[31]=1 the stored word is 0x0000
//   (negative values and -0 clamp to +0); rounding skipped for them.
//  RELU_EN undefined: sign preserved; 0xC0400000 stores 0xC040.
// TESTING
//  Rounding: 0x3F808000->0x3F80 (tie,even); 0x3F818000->0x3F82;
//   0x3F808001->0x3F81; 0x7F7FFFFF->0x7F80; 0x00000000->0x0000.
//  Sign: 0xC0400000 -> 0xC040 without RELU_EN, 0x0000 with RELU_EN;
//   0x80000000 -> 0x8000 / 0x0000.
//  Fill DEPTH=4, out_ready=0, nrm_valid held 6 cycles: 4 accepted, in_ready=0
//   after 4th, count=4, drop=1; then drain 4 in order, count 4->0, out_valid=0.
//  Latency: single push at t into empty FIFO, out_ready=1 -> out_valid only at
//   t+2, popped at t+2, count back to 0 at t+3.
//  Streaming: nrm_valid and out_ready both 1 for 20 cycles -> 20 words out in
//   order, in_ready stays 1, count <=2, pointers wrap, drop=0.
//  init asserted with count=3 and s1_valid=1 -> next cycle count=0,
//   out_valid=0, drop=0; post-init data does not include old entries.

Source files
------------

// File: rtl/tiny_dnn_out_fifo_if.sv
`default_nettype none
// ============================================================================
//  Module      : tiny_dnn_out_fifo_if
//  Description : Producer/consumer bundle for tiny_dnn_out_fifo. It carries the
//                fp32 input side (nrm/nrm_valid/in_ready), the bf16 output side
//                (out_data/out_valid/out_ready) and the status outputs
//                (count, drop).
//  Revision    : 1.0 - initial release
// ============================================================================
interface tiny_dnn_out_fifo_if #(
  parameter int AW = 2
);
  logic          nrm_valid;
  logic [31:0]   nrm;
  logic          in_ready;
  logic          out_valid;
  logic [15:0]   out_data;
  logic          out_ready;
  logic [AW:0]   count;
  logic          drop;

  // Environment side: it produces normalize results and consumes bf16 words.
  modport master (
    output nrm_valid, nrm, out_ready,
    input  in_ready, out_valid, out_data, count, drop
  );

  // Block side.
  modport slave (
    input  nrm_valid, nrm, out_ready,
    output in_ready, out_valid, out_data, count, drop
  );
endinterface
`default_nettype wire

// File: rtl/tiny_dnn_out_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tiny_dnn_out_fifo
//  Description : Takes fp32 normalize results, rounds them to bfloat16 using
//                round-to-nearest-even, and buffers them in a DEPTH-entry FIFO.
//                A valid/ready consumer drains the FIFO.
//                Optional macro RELU_EN: negative inputs (including -0) are
//                stored as +0.
//  Revision    : 1.0 - initial release
// ============================================================================
module tiny_dnn_out_fifo #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  wire logic         clk,
  input  wire logic         init,
  tiny_dnn_out_fifo_if.slave bus
);

  localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0]   ONE_C   = (AW+1)'(1);
  localparam logic [AW-1:0] ONE_P   = AW'(1);

  // Stage-1 holding register (rounded word waiting to be written).
  logic          s1_valid;
  logic [15:0]   s1_data;

  // FIFO storage and bookkeeping.
  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count_q;
  logic [15:0]   out_data_q;
  logic          in_ready_q;
  logic          drop_q;

  // Combinational next-state terms.
  logic          push;
  logic          pop;
  logic          round_inc;
  logic [15:0]   rounded;
  logic [15:0]   s1_next;
  logic [AW:0]   count_after_pop;
  logic [AW:0]   count_next;
  logic [AW:0]   occupancy_next;
  logic [AW-1:0] rd_ptr_next;
  logic          head_from_s1;
  logic          in_ready_next;

  // Handshakes, RNE rounding, and the next occupancy that sets in_ready.
  always_comb begin
    push      = bus.nrm_valid & in_ready_q;
    pop       = (count_q != '0) & bus.out_ready;

    // Round up when above the halfway point, or exactly at halfway with an
    // odd LSB. A mantissa carry ripples into the exponent. This is correct for
    // bf16 and saturates 0x7F7F to +inf.
    round_inc = bus.nrm[15] & (bus.nrm[16] | (|bus.nrm[14:0]));
    rounded   = bus.nrm[31:16] + {15'd0, round_inc};
    s1_next   = rounded;
`ifdef RELU_EN
    if (bus.nrm[31]) begin
      s1_next = 16'h0000;
    end
`endif

    count_after_pop = pop ? (count_q - ONE_C) : count_q;
    count_next      = s1_valid ? (count_after_pop + ONE_C) : count_after_pop;
    rd_ptr_next     = pop ? (rd_ptr + ONE_P) : rd_ptr;

    // The next head is the stage-1 word being written whenever the FIFO
    // empties (or was already empty) on this edge.
    head_from_s1    = s1_valid & (count_after_pop == '0);

    // in_ready is registered from next-state occupancy, so out_ready never
    // reaches it combinationally within the same cycle.
    occupancy_next  = count_next + {{AW{1'b0}}, push};
    in_ready_next   = (occupancy_next < DEPTH_C);
  end

  // Stage 1: capture the rounded word on a push.
  always_ff @(posedge clk) begin
    if (init) begin
      s1_valid <= 1'b0;
      s1_data  <= 16'h0000;
    end else begin
      s1_valid <= push;
      if (push) begin
        s1_data <= s1_next;
      end
    end
  end

  // Storage array: stage-1 word written at wr_ptr. The array has no reset, because count gates it.
  always_ff @(posedge clk) begin
    if (!init && s1_valid) begin
      mem[wr_ptr] <= s1_data;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (init) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (s1_valid) begin
        wr_ptr <= wr_ptr + ONE_P;
      end
      rd_ptr  <= rd_ptr_next;
      count_q <= count_next;
    end
  end

  // Registered head word. It holds while there is no pop, and it keeps its last value when empty.
  always_ff @(posedge clk) begin
    if (init) begin
      out_data_q <= 16'h0000;
    end else if (head_from_s1) begin
      out_data_q <= s1_data;
    end else if (count_after_pop != '0) begin
      out_data_q <= mem[rd_ptr_next];
    end
  end

  // Acceptance flag and sticky drop indicator.
  always_ff @(posedge clk) begin
    if (init) begin
      in_ready_q <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      in_ready_q <= in_ready_next;
      if (bus.nrm_valid && !in_ready_q) begin
        drop_q <= 1'b1;
      end
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = (count_q != '0);
  assign bus.out_data  = out_data_q;
  assign bus.count     = count_q;
  assign bus.drop      = drop_q;

endmodule
`default_nettype wire
